// File: rtl/pc_fetch_ctrl.sv
// Program-counter / instruction-fetch sequencer: fetch with timeout, wait on execute,
// commit one PC update per instruction, and park in HALT or ERROR until reset.
module pc_fetch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             imem_ready,
  input  logic             exec_done,
  input  logic             take_branch,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic             sel_next_pc_alu_out,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StExec   = 3'd2,
    StUpdate = 3'd3,
    StHalt   = 3'd4,
    StError  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             halt_pend_q, halt_pend_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      halt_pend_q <= 1'b0;
      br_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      halt_pend_q <= halt_pend_d;
      br_q        <= br_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    wait_d              = wait_q;
    halt_pend_d         = halt_pend_q;
    br_d                = br_q;
    cnt_d               = cnt_q;
    imem_req            = 1'b0;
    ir_load             = 1'b0;
    pc_en               = 1'b0;
    sel_next_pc_alu_out = 1'b0;
    busy                = 1'b0;
    halted              = 1'b0;
    error               = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        ir_load  = imem_ready;
        if (halt_req) halt_pend_d = 1'b1;
        // A ready on the final wait cycle still wins over the timeout.
        if (imem_ready) begin
          state_d = StExec;
          wait_d  = '0;
        end else if (wait_q == WaitLast) begin
          state_d = StError;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StExec: begin
        busy = 1'b1;
        if (halt_req) halt_pend_d = 1'b1;
        if (exec_done) begin
          br_d    = take_branch;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        busy                = 1'b1;
        pc_en               = 1'b1;
        sel_next_pc_alu_out = br_q;
        cnt_d               = cnt_q + CNT_W'(1);
        if (halt_pend_q || halt_req) begin
          state_d     = StHalt;
          halt_pend_d = 1'b0;
        end else begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        halted = 1'b1;
      end
      StError: begin
        error = 1'b1;
      end
      default: begin
        state_d = StError;
      end
    endcase
  end

  assign state         = state_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by random stimulus, all checked
// every cycle against an instruction-level reference model and an attached pc register.
module tb_pc_fetch_ctrl;

  localparam int unsigned To = 16;
  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, halt_req, imem_ready, exec_done, take_branch;
  logic            imem_req, ir_load, pc_en, sel_next_pc_alu_out, busy, halted, error;
  logic [2:0]      state;
  logic [CntW-1:0] retired_count;

  logic [31:0] alu_out;
  logic [31:0] pc_reg;
  int          pulses;
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: phase 0 idle, 1 fetch, 2 exec, 3 commit, 4 halted, 5 error.
  int m_phase;
  int m_misses;
  int m_cnt;
  bit m_stop;
  bit m_br;

  pc_fetch_ctrl #(
    .TIMEOUT_CYCLES(To),
    .CNT_W         (CntW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .halt_req           (halt_req),
    .imem_ready         (imem_ready),
    .exec_done          (exec_done),
    .take_branch        (take_branch),
    .imem_req           (imem_req),
    .ir_load            (ir_load),
    .pc_en              (pc_en),
    .sel_next_pc_alu_out(sel_next_pc_alu_out),
    .busy               (busy),
    .halted             (halted),
    .error              (error),
    .state              (state),
    .retired_count      (retired_count)
  );

  always #5 clk = ~clk;

  // The pc register this block would drive in the datapath.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= 32'd0;
    end else if (pc_en) begin
      pc_reg <= sel_next_pc_alu_out ? alu_out : pc_reg + 32'd4;
      pulses <= pulses + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_misses = 0;
    m_cnt    = 0;
    m_stop   = 0;
    m_br     = 0;
  endtask

  task automatic model_step(input bit s, input bit h, input bit r, input bit d, input bit b);
    case (m_phase)
      0: m_phase = h ? 4 : (s ? 1 : 0);
      1: begin
        if (h) m_stop = 1;
        if (r) begin
          m_phase  = 2;
          m_misses = 0;
        end else begin
          m_misses++;
          if (m_misses == To) begin
            m_phase  = 5;
            m_misses = 0;
          end
        end
      end
      2: begin
        if (h) m_stop = 1;
        if (d) begin
          m_br    = b;
          m_phase = 3;
        end
      end
      3: begin
        m_cnt   = (m_cnt + 1) % (1 << CntW);
        m_phase = (m_stop || h) ? 4 : 1;
        if (m_phase == 4) m_stop = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("state", {29'd0, state}, m_phase);
    chk("imem_req", imem_req, m_phase == 1);
    chk("ir_load", ir_load, (m_phase == 1) && imem_ready);
    chk("pc_en", pc_en, m_phase == 3);
    chk("sel_next_pc_alu_out", sel_next_pc_alu_out, (m_phase == 3) && m_br);
    chk("busy", busy, m_phase >= 1 && m_phase <= 3);
    chk("halted", halted, m_phase == 4);
    chk("error", error, m_phase == 5);
    chk("retired_count", {28'd0, retired_count}, m_cnt);
  endtask

  // One clock: drive at the falling edge, check, then advance model at the rising edge.
  task automatic cyc(input bit s, input bit h, input bit r, input bit d, input bit b);
    @(negedge clk);
    start       = s;
    halt_req    = h;
    imem_ready  = r;
    exec_done   = d;
    take_branch = b;
    #1 check_all();
    @(posedge clk);
    model_step(s, h, r, d, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    {start, halt_req, imem_ready, exec_done, take_branch} = '0;
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One instruction from FETCH through the commit cycle.
  task automatic instr(input int rd, input int ed, input bit b, input bit hlt);
    for (int i = 0; i < rd; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < ed; i++) cyc(0, hlt && (i == 0), 0, 0, 0);
    cyc(0, hlt && (ed == 0), 0, 1, b);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {start, halt_req, imem_ready, exec_done, take_branch} = '0;
    alu_out = 32'd0;
    pulses  = 0;
    model_reset();
    #1 check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single sequential instruction: pc 0 -> 4.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    instr(0, 1, 0, 0);
    chk("pc_first", pc_reg, 32'd4);
    chk("retired_first", {28'd0, retired_count}, 32'd1);

    // Three back-to-back, middle one branches to 40.
    do_reset();
    pulses  = 0;
    alu_out = 32'd40;
    cyc(1, 0, 0, 0, 0);
    instr(0, 0, 0, 0);
    chk("pc_seq0", pc_reg, 32'd4);
    instr(1, 2, 1, 0);
    chk("pc_seq1", pc_reg, 32'd40);
    instr(2, 0, 0, 0);
    chk("pc_seq2", pc_reg, 32'd44);
    chk("pc_en_pulses", pulses, 32'd3);
    chk("retired_three", {28'd0, retired_count}, 32'd3);

    // Ready on the last allowed wait cycle, then a real timeout.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("late_ready_exec", {29'd0, state}, 32'd2);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0);
    chk("timeout_state", {29'd0, state}, 32'd5);
    chk("timeout_error", error, 1'b1);
    chk("timeout_req", imem_req, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1, i[0], 1, 1, 0);
    chk("error_sticky", error, 1'b1);

    // Halt during EXEC still commits, then HALT ignores start.
    do_reset();
    pulses = 0;
    cyc(1, 0, 0, 0, 0);
    instr(0, 2, 0, 1);
    chk("halt_commit", pulses, 32'd1);
    chk("halt_state", halted, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 0);
    chk("halt_sticky", {29'd0, state}, 32'd4);

    // start and halt_req together in IDLE.
    do_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("idle_halt", {29'd0, state}, 32'd4);
    chk("idle_halt_cnt", {28'd0, retired_count}, 32'd0);

    // Asynchronous reset in the middle of EXEC.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    instr(0, 0, 0, 0);
    pulses = 0;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    do_reset();
    chk("async_no_pc_en", pulses, 32'd0);
    chk("async_pc_cleared", pc_reg, 32'd0);

    // Random traffic; recover from HALT/ERROR with a reset.
    for (int n = 0; n < 600; n++) begin
      if (m_phase >= 4 && $urandom_range(0, 3) == 0) do_reset();
      alu_out = {$urandom_range(0, 255), 2'b00};
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
